// File: rtl/cnn16_pkg.sv
// Shared constants and helpers for the CNN-16 memory subsystem.
// Holds default widths, requester port indices and a tag-width helper.
package cnn16_pkg;

  localparam int CNN_DATA_W = 16;
  localparam int CNN_ADDR_W = 12;

  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;

  // Bits needed to index n items, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cnn_mem_subsys_if.sv
// Multi-port request/response bus between masters and cnn_mem_subsys.
// Ports: req/we/addr/wdata from masters; ready/rvalid/rdata back.
interface cnn_mem_subsys_if
  import cnn16_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = CNN_DATA_W,
  parameter int ADDR_WIDTH = CNN_ADDR_W
);

  logic [NUM_PORTS-1:0]            req;
  logic [NUM_PORTS-1:0]            we;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata;
  logic [NUM_PORTS-1:0]            ready;
  logic [NUM_PORTS-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]           rdata;

  modport master (
    output req, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/cnn_rr_arbiter.sv
// Round-robin arbiter: search starts at ptr, first requester wins.
// Ports: req, ptr in; one-hot grant and ptr_next (g+1 wrap, or hold) out.
module cnn_rr_arbiter
  import cnn16_pkg::*;
#(
  parameter int N = 2,
  localparam int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] ptr_next
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] rot_w;
  logic [2*N-1:0] gdbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   hot;
  logic [PW:0]    off;
  logic [PW:0]    sum;
  logic           hit;

  always_comb begin
    dbl   = {req, req};
    // rot[k] is the request of port (ptr+k) mod N
    rot_w = dbl >> ptr;
    rot   = rot_w[N-1:0];
    hot   = '0;
    off   = '0;
    hit   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        hot    = '0;
        hot[k] = 1'b1;
        off    = (PW+1)'(k);
        hit    = 1'b1;
      end
    end
    // rotate the winner back to absolute port numbering
    gdbl  = {{N{1'b0}}, hot} << ptr;
    grant = gdbl[N-1:0] | gdbl[2*N-1:N];
    sum   = {1'b0, ptr} + off + (PW+1)'(1);
    ptr_next = ptr;
    if (hit) begin
      if (sum >= (PW+1)'(N))
        ptr_next = PW'(sum - (PW+1)'(N));
      else
        ptr_next = PW'(sum);
    end
  end

endmodule

// File: rtl/cnn_mem_subsys.sv
// Shared synchronous RAM with round-robin access and fixed read latency.
// Ports: clk, rst (async, active high), bus (slave side of the memory bus).
module cnn_mem_subsys
  import cnn16_pkg::*;
#(
  parameter int DATA_WIDTH   = CNN_DATA_W,
  parameter int ADDR_WIDTH   = CNN_ADDR_W,
  parameter int NUM_PORTS    = 2,
  parameter int READ_LATENCY = 1
) (
  input logic           clk,
  input logic           rst,
  cnn_mem_subsys_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int TW    = clog2(NUM_PORTS);
  localparam int L     = READ_LATENCY;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
    $fatal(1, "cnn_mem_subsys: READ_LATENCY must be 1..4");
  end
  if (NUM_PORTS < 1 || NUM_PORTS > 8) begin : g_bad_ports
    $fatal(1, "cnn_mem_subsys: NUM_PORTS must be 1..8");
  end

  logic [NUM_PORTS-1:0]  arb_req;
  logic [NUM_PORTS-1:0]  grant;
  logic [TW-1:0]         ptr;
  logic [TW-1:0]         ptr_next;
  logic [TW-1:0]         gidx;
  logic                  go;
  logic                  go_wr;
  logic                  go_rd;
  logic [ADDR_WIDTH-1:0] ga;
  logic [DATA_WIDTH-1:0] gd;

  logic [DATA_WIDTH-1:0]        mem [DEPTH];
  logic [L-1:0][DATA_WIDTH-1:0] pd;
  logic [L-1:0][TW-1:0]         pt;
  logic [L-1:0]                 pv;

  // no grant can be issued while reset is held
  assign arb_req = bus.req & {NUM_PORTS{~rst}};

  cnn_rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .req      (arb_req),
    .ptr      (ptr),
    .grant    (grant),
    .ptr_next (ptr_next)
  );

  assign bus.ready = grant;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (grant[i]) gidx = TW'(i);
    go    = |grant;
    ga    = bus.addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
    gd    = bus.wdata[gidx*DATA_WIDTH +: DATA_WIDTH];
    go_wr = go & bus.we[gidx];
    go_rd = go & ~bus.we[gidx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else     ptr <= ptr_next;
  end

  // array and read-data pipeline carry no reset
  always_ff @(posedge clk) begin
    if (go_wr) mem[ga] <= gd;
    if (go_rd) pd[0] <= mem[ga];
    for (int i = 1; i < L; i++)
      pd[i] <= pd[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv         <= '0;
      pt         <= '0;
      bus.rvalid <= '0;
      bus.rdata  <= '0;
    end else begin
      pv[0] <= go_rd;
      pt[0] <= gidx;
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pt[i] <= pt[i-1];
      end
      bus.rvalid <= pv[L-1] ?
        (NUM_PORTS'(1) << pt[L-1]) : '0;
      if (pv[L-1]) bus.rdata <= pd[L-1];
    end
  end

endmodule

// File: tb/tb_cnn_mem_subsys.sv
// Scoreboard bench for cnn_mem_subsys: 2 ports, read latency 3.
// Directed scenarios followed by randomized traffic against a model.
module tb_cnn_mem_subsys;
  import cnn16_pkg::*;

  localparam int NP  = 2;
  localparam int DW  = 16;
  localparam int AW  = 12;
  localparam int LAT = 3;

  typedef struct {
    int          port;
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clk;
  logic rst;

  cnn_mem_subsys_if #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) bus ();

  cnn_mem_subsys #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .NUM_PORTS(NP), .READ_LATENCY(LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mdl [4096];
  exp_t        q [$];
  int          rr;
  int          cyc;
  int          total;
  int          bad;
  int          g;
  exp_t        e;

  logic [1:0]  p_req;
  logic [1:0]  p_we;
  logic [11:0] p_a [2];
  logic [15:0] p_d [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // One bus cycle: drive, check the grant against the model,
  // and apply the granted access to the model.
  task automatic cycle(input logic [1:0] r, input logic [1:0] w,
                       input logic [11:0] a0, input logic [11:0] a1,
                       input logic [15:0] d0, input logic [15:0] d1,
                       output int gi);
    logic [1:0]  expg;
    logic [11:0] a;
    logic [15:0] d;
    exp_t        n;
    @(negedge clk);
    bus.req   = r;
    bus.we    = w;
    bus.addr  = {a1, a0};
    bus.wdata = {d1, d0};
    #1;
    gi = -1;
    if (!rst)
      for (int k = 0; k < NP; k++)
        if (gi < 0 && r[(rr + k) % NP]) gi = (rr + k) % NP;
    expg = (gi >= 0) ? 2'(1 << gi) : 2'b00;
    chk("ready", 32'(bus.ready), 32'(expg));
    if (gi >= 0) begin
      rr = (gi + 1) % NP;
      a  = (gi == 0) ? a0 : a1;
      d  = (gi == 0) ? d0 : d1;
      if (w[gi]) mdl[a] = d;
      else begin
        n.port = gi;
        n.data = mdl[a];
        n.due  = cyc + 1 + LAT;
        q.push_back(n);
      end
    end
  endtask

  task automatic idle(input int n);
    int gi;
    for (int i = 0; i < n; i++)
      cycle(2'b00, 2'b00, 12'h0, 12'h0, 16'h0, 16'h0, gi);
  endtask

  // Monitor: every returned word must match the oldest pending read.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (bus.rvalid !== 2'b00) begin
      if (q.size() == 0) begin
        chk("spurious_rvalid", 32'(bus.rvalid), 32'h0);
      end else begin
        e = q.pop_front();
        chk("rvalid_tag", 32'(bus.rvalid), 32'(1 << e.port));
        chk("rdata", 32'(bus.rdata), 32'(e.data));
        chk("latency", 32'(cyc), 32'(e.due));
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      chk("rvalid_missing", 32'(bus.rvalid), 32'(1 << q[0].port));
      void'(q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rr    = 0;
    p_req = '0;
    p_we  = '0;
    bus.req   = 2'b11;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    rst = 1'b1;

    // reset state, with requests present
    #12;
    chk("rst_ready", 32'(bus.ready), 32'h0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
    chk("rst_rdata", 32'(bus.rdata), 32'h0);
    bus.req = '0;
    @(posedge clk);
    #2 rst = 1'b0;

    // single write then read on port 0
    cycle(2'b01, 2'b01, 12'h010, 12'h0, 16'hBEEF, 16'h0, g);
    cycle(2'b01, 2'b00, 12'h010, 12'h0, 16'h0, 16'h0, g);
    idle(LAT + 1);

    // contention: both ports reading continuously
    cycle(2'b01, 2'b01, 12'h000, 12'h0, 16'h1111, 16'h0, g);
    cycle(2'b10, 2'b10, 12'h0, 12'hFFF, 16'h0, 16'h2222, g);
    for (int i = 0; i < 4; i++)
      cycle(2'b11, 2'b00, 12'h000, 12'hFFF, 16'h0, 16'h0, g);
    idle(LAT + 1);

    // back-to-back reads on port 1
    cycle(2'b10, 2'b10, 12'h0, 12'h005, 16'h0, 16'h00A5, g);
    cycle(2'b10, 2'b10, 12'h0, 12'h006, 16'h0, 16'h00A6, g);
    cycle(2'b10, 2'b00, 12'h0, 12'h005, 16'h0, 16'h0, g);
    cycle(2'b10, 2'b00, 12'h0, 12'h006, 16'h0, 16'h0, g);
    idle(LAT + 1);

    // read-after-write across ports
    cycle(2'b01, 2'b01, 12'h020, 12'h0, 16'h1234, 16'h0, g);
    cycle(2'b10, 2'b00, 12'h0, 12'h020, 16'h0, 16'h0, g);
    idle(LAT + 1);

    // idle, then pointer hold after a port-1 grant
    idle(10);
    cycle(2'b10, 2'b00, 12'h0, 12'h020, 16'h0, 16'h0, g);
    idle(3);
    cycle(2'b11, 2'b00, 12'h010, 12'h020, 16'h0, 16'h0, g);
    cycle(2'b10, 2'b00, 12'h010, 12'h020, 16'h0, 16'h0, g);
    idle(LAT + 1);

    // reset two cycles after a read accept
    cycle(2'b10, 2'b00, 12'h0, 12'h010, 16'h0, 16'h0, g);
    idle(2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    bus.req = 2'b11;
    #1;
    chk("midrst_ready", 32'(bus.ready), 32'h0);
    chk("midrst_rvalid", 32'(bus.rvalid), 32'h0);
    chk("midrst_rdata", 32'(bus.rdata), 32'h0);
    q.delete();
    rr = 0;
    cycle(2'b11, 2'b00, 12'h010, 12'h020, 16'h0, 16'h0, g);
    cycle(2'b11, 2'b00, 12'h010, 12'h020, 16'h0, 16'h0, g);
    bus.req = '0;
    @(posedge clk);
    #2 rst = 1'b0;
    cycle(2'b11, 2'b00, 12'h010, 12'h020, 16'h0, 16'h0, g);
    cycle(2'b10, 2'b00, 12'h010, 12'h020, 16'h0, 16'h0, g);
    idle(LAT + 2);

    // preload the random working set
    for (int a = 0; a <= 64; a++)
      cycle(2'b01, 2'b01, (a == 64) ? 12'hFFF : 12'(a), 12'h0,
            16'($urandom), 16'h0, g);

    // random traffic with held requests and early drops
    for (int n = 0; n < 1500; n++) begin
      for (int p = 0; p < NP; p++) begin
        if (!p_req[p]) begin
          if ($urandom_range(0, 2) != 0) begin
            int ra;
            ra = $urandom_range(0, 64);
            p_req[p] = 1'b1;
            p_we[p]  = 1'($urandom_range(0, 1));
            p_a[p]   = (ra == 64) ? 12'hFFF : 12'(ra);
            p_d[p]   = 16'($urandom);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          p_req[p] = 1'b0;
        end
      end
      cycle(p_req, p_we, p_a[0], p_a[1], p_d[0], p_d[1], g);
      if (g >= 0) p_req[g] = 1'b0;
    end

    idle(LAT + 3);
    chk("drain", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
